// File: rtl/usb_ctrl_xfer_host.sv
// Host-side control-transfer initiator: writes a SETUP packet into a control endpoint,
// runs the IN data stage (device-to-host only) and the status stage, then reports the outcome.
module usb_ctrl_xfer_host #(
  parameter int unsigned MaxPktSizeByte = 32,
  parameter int unsigned PktW           = $clog2(MaxPktSizeByte),
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [63:0]     req_setup_i,
  output logic            rsp_valid_o,
  output logic [7:0]      rsp_data_o,
  output logic            done_o,
  output logic            stall_o,
  output logic            err_o,
  output logic [15:0]     xfer_len_o,
  output logic            out_ep_data_put_o,
  output logic [PktW-1:0] out_ep_put_addr_o,
  output logic [7:0]      out_ep_data_o,
  output logic            out_ep_acked_o,
  output logic            out_ep_rollback_o,
  output logic            out_ep_setup_o,
  output logic            in_ep_data_get_o,
  output logic [PktW-1:0] in_ep_get_addr_o,
  output logic            in_ep_acked_o,
  output logic            in_ep_rollback_o,
  input  logic            in_ep_has_data_i,
  input  logic [7:0]      in_ep_data_i,
  input  logic            in_ep_stall_i
);

  localparam int unsigned TimerW  = $clog2(TimeoutCycles + 1);
  localparam int unsigned PktCntW = $clog2(MaxPktSizeByte + 1);
  localparam logic [TimerW-1:0]  TimerMax = TimerW'(TimeoutCycles);
  localparam logic [PktCntW-1:0] PktMax   = PktCntW'(MaxPktSizeByte);

  typedef enum logic [2:0] {
    IDLE, SETUP_WR, SETUP_ACK, DATA_IN, IN_ACK, STATUS_OUT, STATUS_IN, DONE
  } state_e;

  state_e              state_reg, state_next;
  logic [63:0]         setup_reg, setup_next;
  logic [2:0]          idx_reg, idx_next;
  logic [15:0]         count_reg, count_next;
  logic [PktCntW-1:0]  pkt_idx_reg, pkt_idx_next;
  logic [TimerW-1:0]   timer_reg, timer_next;
  logic                stall_reg, stall_next;
  logic                err_reg, err_next;
  logic                rsp_valid_reg;
  logic [7:0]          rsp_data_reg;
  logic [15:0]         wlen;
  logic                get_en;

  assign wlen   = setup_reg[63:48];
  assign get_en = (state_reg == DATA_IN) && !in_ep_stall_i && in_ep_has_data_i &&
                  (count_reg < wlen) && (pkt_idx_reg < PktMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      setup_reg     <= '0;
      idx_reg       <= '0;
      count_reg     <= '0;
      pkt_idx_reg   <= '0;
      timer_reg     <= '0;
      stall_reg     <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      setup_reg     <= setup_next;
      idx_reg       <= idx_next;
      count_reg     <= count_next;
      pkt_idx_reg   <= pkt_idx_next;
      timer_reg     <= timer_next;
      stall_reg     <= stall_next;
      err_reg       <= err_next;
      rsp_valid_reg <= get_en;
      if (get_en) begin
        rsp_data_reg <= in_ep_data_i;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    setup_next   = setup_reg;
    idx_next     = idx_reg;
    count_next   = count_reg;
    pkt_idx_next = pkt_idx_reg;
    timer_next   = timer_reg;
    stall_next   = stall_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          setup_next   = req_setup_i;
          idx_next     = '0;
          count_next   = '0;
          pkt_idx_next = '0;
          timer_next   = '0;
          stall_next   = 1'b0;
          err_next     = 1'b0;
          // Host-to-device requests with a data stage are rejected before touching the bus.
          if (!req_setup_i[7] && (req_setup_i[63:48] != 16'd0)) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = SETUP_WR;
          end
        end
      end
      SETUP_WR: begin
        idx_next = idx_reg + 3'd1;
        if (idx_reg == 3'd7) begin
          state_next = SETUP_ACK;
        end
      end
      SETUP_ACK: begin
        state_next = (wlen == 16'd0) ? STATUS_IN : DATA_IN;
      end
      DATA_IN: begin
        if (in_ep_stall_i) begin
          stall_next = 1'b1;
          state_next = DONE;
        end else if (get_en) begin
          count_next   = count_reg + 16'd1;
          pkt_idx_next = pkt_idx_reg + PktCntW'(1);
          if ((count_next == wlen) || (pkt_idx_next == PktMax)) begin
            state_next = IN_ACK;
          end
        end else if (pkt_idx_reg != '0) begin
          // Endpoint ran dry mid-packet: this is a short packet.
          state_next = IN_ACK;
        end else if (!in_ep_has_data_i) begin
          if (timer_reg != TimerMax) begin
            timer_next = timer_reg + TimerW'(1);
          end
          if (timer_next == TimerMax) begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      IN_ACK: begin
        pkt_idx_next = '0;
        state_next   = ((count_reg < wlen) && in_ep_has_data_i) ? DATA_IN : STATUS_OUT;
      end
      STATUS_OUT: begin
        state_next = DONE;
      end
      STATUS_IN: begin
        if (in_ep_stall_i) begin
          stall_next = 1'b1;
          state_next = DONE;
        end else if (in_ep_has_data_i) begin
          state_next = DONE;
        end else begin
          if (timer_reg != TimerMax) begin
            timer_next = timer_reg + TimerW'(1);
          end
          if (timer_next == TimerMax) begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready_o       = (state_reg == IDLE);
    done_o            = 1'b0;
    stall_o           = 1'b0;
    err_o             = 1'b0;
    xfer_len_o        = '0;
    out_ep_data_put_o = 1'b0;
    out_ep_put_addr_o = '0;
    out_ep_data_o     = '0;
    out_ep_acked_o    = 1'b0;
    out_ep_setup_o    = 1'b0;
    in_ep_data_get_o  = 1'b0;
    in_ep_get_addr_o  = '0;
    in_ep_acked_o     = 1'b0;
    case (state_reg)
      SETUP_WR: begin
        out_ep_setup_o    = 1'b1;
        out_ep_data_put_o = 1'b1;
        out_ep_put_addr_o = PktW'(idx_reg);
        out_ep_data_o     = setup_reg[{idx_reg, 3'b000} +: 8];
      end
      SETUP_ACK: begin
        out_ep_acked_o = 1'b1;
        out_ep_setup_o = 1'b1;
      end
      DATA_IN: begin
        in_ep_data_get_o = get_en;
        if (get_en) begin
          in_ep_get_addr_o = PktW'(pkt_idx_reg);
        end
      end
      IN_ACK: begin
        in_ep_acked_o = 1'b1;
      end
      STATUS_OUT: begin
        out_ep_acked_o = 1'b1;
      end
      STATUS_IN: begin
        in_ep_acked_o = in_ep_has_data_i && !in_ep_stall_i;
      end
      DONE: begin
        done_o     = 1'b1;
        stall_o    = stall_reg;
        err_o      = err_reg;
        xfer_len_o = count_reg;
      end
      default: begin
      end
    endcase
  end

  assign rsp_valid_o       = rsp_valid_reg;
  assign rsp_data_o        = rsp_data_reg;
  assign out_ep_rollback_o = 1'b0;
  assign in_ep_rollback_o  = 1'b0;

endmodule

// File: doc/usb_ctrl_xfer_host.md
Name: usb_ctrl_xfer_host

Overview:
- Host-side initiator for USB control transfers; it drives the device-side control endpoint's OUT-put/IN-get interface directly, with no wire-level USB in between.
- Accepts one 8-byte SETUP request and writes it as a SETUP packet.
- For device-to-host requests it runs the IN data stage and streams the returned bytes out; it then performs the status stage and reports completion, stall or timeout.
- Used for on-chip self-enumeration, BIST and endpoint bring-up.

Parameters:
- MaxPktSizeByte, 32, max bytes per IN data packet; must match the endpoint.
- PktW, $clog2(MaxPktSizeByte), packet address width.
- TimeoutCycles, 1024, cycles to wait for the endpoint before aborting.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_setup_i  in  64  SETUP bytes; byte n is [8n+7:8n]; byte0 = bmRequestType.
- rsp_valid_o  out  1  one received IN data byte; no backpressure.
- rsp_data_o  out  8  received byte.
- done_o  out  1  one-cycle completion pulse.
- stall_o  out  1  valid with done_o; endpoint stalled.
- err_o  out  1  valid with done_o; timeout or unsupported request.
- xfer_len_o  out  16  valid with done_o; data bytes received.
- out_ep_data_put_o  out  1  SETUP byte write strobe.
- out_ep_put_addr_o  out  PktW  byte index.
- out_ep_data_o  out  8  byte.
- out_ep_acked_o  out  1  OUT/SETUP packet acknowledged.
- out_ep_rollback_o  out  1  tied 0.
- out_ep_setup_o  out  1  current OUT packet is SETUP.
- in_ep_data_get_o  out  1  IN byte read strobe.
- in_ep_get_addr_o  out  PktW  IN byte index within the packet.
- in_ep_acked_o  out  1  IN packet acknowledged.
- in_ep_rollback_o  out  1  tied 0.
- in_ep_has_data_i  in  1  endpoint has IN data or a zero-length packet.
- in_ep_data_i  in  8  combinational IN data at the current endpoint pointer.
- in_ep_stall_i  in  1  endpoint stall.

Behaviour:

Reset
- All outputs are 0 except req_ready_o=1. State is IDLE and all counters are 0.
- Reset assertion mid-transfer aborts immediately: no done_o and no further strobes.

IDLE
- On req_valid_i: latch req_setup_i; clear count and timer.
- If bmRequestType[7]=0 and wLength!=0 (OUT data stage unsupported): go to DONE with err_o=1 and no bus activity.
- Otherwise go to SETUP_WR.

SETUP_WR (8 cycles, idx 0..7)
- out_ep_setup_o=1, out_ep_data_put_o=1, out_ep_put_addr_o=idx, out_ep_data_o=byte idx.

SETUP_ACK (1 cycle)
- out_ep_acked_o=1 and out_ep_setup_o=1.
- Next state: STATUS_IN if wLength==0, else DATA_IN.

DATA_IN
- Priority 1: in_ep_stall_i=1 → DONE with stall_o=1; no ack is sent.
- Get condition: in_ep_has_data_i=1 and count<wLength and pkt_idx<MaxPktSizeByte.
  - Assert in_ep_data_get_o with in_ep_get_addr_o=pkt_idx.
  - Register in_ep_data_i into rsp_data_o; rsp_valid_o=1 on the next cycle (latency 1).
  - count+1, pkt_idx+1.
- Go to IN_ACK when any of these holds:
  - in_ep_has_data_i falls with pkt_idx>0;
  - count reaches wLength;
  - pkt_idx reaches MaxPktSizeByte.
- With pkt_idx==0 and has_data low, the timer increments. At TimeoutCycles → DONE with err_o=1.

IN_ACK (1 cycle)
- in_ep_acked_o=1; pkt_idx is set to 0.
- If count<wLength and in_ep_has_data_i=1 → DATA_IN.
- Else → STATUS_OUT. A short packet ends the stage.

STATUS_OUT (1 cycle)
- out_ep_acked_o=1 with out_ep_setup_o=0 (zero-length OUT), then DONE.

STATUS_IN
- Wait for in_ep_has_data_i, which signals the zero-length packet.
- Then pulse in_ep_acked_o for one cycle and go to DONE.
- The timeout applies while waiting.

DONE (1 cycle)
- done_o=1; stall_o, err_o and xfer_len_o=count are driven this cycle only. Then → IDLE.

Width and arithmetic rules
- count is 16-bit, compared unsigned against wLength = {byte7, byte6}.
- The timer saturates at TimeoutCycles.

Simultaneous events
- req_valid_i outside IDLE is ignored.
- Stall has priority over get in DATA_IN.
- At most one of out_ep_acked_o / in_ep_acked_o is high per cycle.

Test Plan:
1. Device descriptor: setup 80 06 00 01 00 00 40 00 → exactly 18 rsp bytes: 12 01 00 02 00 00 00 20 D1 18 39 50 00 01 00 00 00 01. Then one in_ep_acked_o, one zero-length OUT ack, done_o with xfer_len_o=18, stall_o=0, err_o=0.
2. SET_ADDRESS: setup 00 05 07 00 00 00 00 00 → 8 puts, no get. STATUS_IN acks the zero-length packet; done_o with xfer_len_o=0. The endpoint's dev_addr reads 7 afterwards.
3. Device-qualifier: setup 80 06 00 06 00 00 0A 00 → no get, no IN ack; done_o with stall_o=1.
4. Configuration descriptor truncated: setup 80 06 00 02 00 00 09 00 → 9 bytes 09 02 20 00 01 01 00 C0 32; done_o with xfer_len_o=9.
5. Timeout and unsupported request:
   - Tie in_ep_has_data_i=0 after a GET → done_o with err_o=1 exactly TimeoutCycles cycles after entering DATA_IN.
   - Setup 00 09 01 00 00 00 02 00 → immediate done_o with err_o=1 and no put strobes.
6. Reset mid-transfer: assert rst_ni=0 on the 5th received byte of case 1 → all strobes drop the same cycle, no done_o, req_ready_o=1. A fresh GET then succeeds once the endpoint has also been reset.
